// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl_if
// Description : Signal bundle between the UART receive controller and its
//               surroundings (serial line, configuration, edge/bit counter,
//               sampler, received byte and status pulses).
//               master : line/config/counter side (drives the controller inputs)
//               slave  : the uart_rx_ctrl controller
// Signals     : RX_IN, Prescale[5:0], PAR_EN, PAR_TYP, edge_count[4:0],
//               bit_count[3:0], sampled_bit            (master -> slave)
//               counter_enable, cfg_prescale[5:0], P_DATA[7:0], data_valid,
//               par_err, stop_err, start_glitch        (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_ctrl_if;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [4:0] edge_count;
    logic [3:0] bit_count;
    logic       sampled_bit;
    logic       counter_enable;
    logic [5:0] cfg_prescale;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stop_err;
    logic       start_glitch;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP, edge_count, bit_count, sampled_bit,
        input  counter_enable, cfg_prescale, P_DATA, data_valid, par_err, stop_err,
               start_glitch
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP, edge_count, bit_count, sampled_bit,
        output counter_enable, cfg_prescale, P_DATA, data_valid, par_err, stop_err,
               start_glitch
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : Frame-level control FSM of a UART receiver. Detects the start
//               level, runs an external edge/bit counter, shifts in the data
//               bits delivered by an external sampler (LSB first), optionally
//               checks parity, validates the stop bit and reports the byte or
//               a one-cycle error pulse.
// Ports       : clk  - clock, rising edge active
//               rst  - asynchronous reset, active low
//               bus  - uart_rx_ctrl_if.slave (line, config, counter/sampler
//                      inputs; counter_enable, cfg_prescale, P_DATA,
//                      data_valid, par_err, stop_err, start_glitch outputs)
// Build macro : UART_RX_PARITY_EN - when defined, the PARITY state and par_err
//               are active; when undefined PAR_EN/PAR_TYP are ignored and
//               par_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl (
    input  wire logic     clk,
    input  wire logic     rst,
    uart_rx_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_VALID  = 3'd5
    } state_t;

    localparam logic [5:0] c_RESET_PRESCALE = 6'd8;
    localparam logic [3:0] c_LAST_DATA_BIT  = 4'd8;

    state_t     state_q,          state_d;
    logic [5:0] cfg_prescale_q,   cfg_prescale_d;
    logic       par_en_q,         par_en_d;
    logic       par_typ_q,        par_typ_d;
    logic [7:0] shift_q,          shift_d;
    logic       par_pend_q,       par_pend_d;
    logic [7:0] p_data_q,         p_data_d;
    logic       counter_enable_q, counter_enable_d;
    logic       data_valid_q,     data_valid_d;
    logic       par_err_q,        par_err_d;
    logic       stop_err_q,       stop_err_d;
    logic       start_glitch_q,   start_glitch_d;

    logic       w_bit_end;
    logic       w_prescale_ok;
    logic       w_start_req;
    logic       w_launch;
    logic       w_par_en_in;
    logic       w_par_typ_in;

`ifdef UART_RX_PARITY_EN
    assign w_par_en_in  = bus.PAR_EN;
    assign w_par_typ_in = bus.PAR_TYP;
    assign bus.par_err  = par_err_q;
`else
    // Parity support is compiled out: the latched enable stays 0 so the
    // PARITY state is unreachable and no parity error can ever be pending.
    logic w_unused_parity;
    assign w_par_en_in     = 1'b0;
    assign w_par_typ_in    = 1'b0;
    assign bus.par_err     = 1'b0;
    assign w_unused_parity = ^{bus.PAR_EN, bus.PAR_TYP, par_err_q};
`endif

    // Last counter edge of the current bit, using the ratio latched for this frame.
    assign w_bit_end     = ({1'b0, bus.edge_count} == (cfg_prescale_q - 6'd1));
    assign w_prescale_ok = (bus.Prescale == 6'd8) || (bus.Prescale == 6'd16) ||
                           (bus.Prescale == 6'd32);
    // A start is only honoured with a supported ratio, so an unsupported value
    // can never be latched into cfg_prescale.
    assign w_start_req   = !bus.RX_IN && w_prescale_ok;

    always_comb begin
        state_d          = state_q;
        cfg_prescale_d   = cfg_prescale_q;
        par_en_d         = par_en_q;
        par_typ_d        = par_typ_q;
        shift_d          = shift_q;
        par_pend_d       = par_pend_q;
        p_data_d         = p_data_q;
        counter_enable_d = counter_enable_q;
        data_valid_d     = 1'b0;
        par_err_d        = 1'b0;
        stop_err_d       = 1'b0;
        start_glitch_d   = 1'b0;
        w_launch         = 1'b0;

        case (state_q)
            S_IDLE: begin
                w_launch = w_start_req;
            end

            S_START: begin
                if (w_bit_end) begin
                    if (bus.sampled_bit) begin
                        // Line was back high at mid-bit: noise, not a start bit.
                        start_glitch_d   = 1'b1;
                        state_d          = S_IDLE;
                        counter_enable_d = 1'b0;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    shift_d = {bus.sampled_bit, shift_q[7:1]};
                    if (bus.bit_count == c_LAST_DATA_BIT) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end
                end
            end

            S_PARITY: begin
                if (w_bit_end) begin
                    // Error is held until the stop bit so both faults report together.
                    if (bus.sampled_bit != ((^shift_q) ^ par_typ_q)) begin
                        par_pend_d = 1'b1;
                    end
                    state_d = S_STOP;
                end
            end

            S_STOP: begin
                if (w_bit_end) begin
                    counter_enable_d = 1'b0;
                    if (bus.sampled_bit && !par_pend_q) begin
                        state_d      = S_VALID;
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end else begin
                        state_d    = S_IDLE;
                        stop_err_d = !bus.sampled_bit;
                        par_err_d  = par_pend_q;
                    end
                end
            end

            S_VALID: begin
                // Back-to-back frames: a low line here is the next start bit.
                w_launch = w_start_req;
                if (!w_start_req) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d          = S_IDLE;
                counter_enable_d = 1'b0;
            end
        endcase

        if (w_launch) begin
            state_d          = S_START;
            cfg_prescale_d   = bus.Prescale;
            par_en_d         = w_par_en_in;
            par_typ_d        = w_par_typ_in;
            shift_d          = 8'h00;
            par_pend_d       = 1'b0;
            counter_enable_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            cfg_prescale_q   <= c_RESET_PRESCALE;
            par_en_q         <= 1'b0;
            par_typ_q        <= 1'b0;
            shift_q          <= 8'h00;
            par_pend_q       <= 1'b0;
            p_data_q         <= 8'h00;
            counter_enable_q <= 1'b0;
            data_valid_q     <= 1'b0;
            par_err_q        <= 1'b0;
            stop_err_q       <= 1'b0;
            start_glitch_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            cfg_prescale_q   <= cfg_prescale_d;
            par_en_q         <= par_en_d;
            par_typ_q        <= par_typ_d;
            shift_q          <= shift_d;
            par_pend_q       <= par_pend_d;
            p_data_q         <= p_data_d;
            counter_enable_q <= counter_enable_d;
            data_valid_q     <= data_valid_d;
            par_err_q        <= par_err_d;
            stop_err_q       <= stop_err_d;
            start_glitch_q   <= start_glitch_d;
        end
    end

    assign bus.counter_enable = counter_enable_q;
    assign bus.cfg_prescale   = cfg_prescale_q;
    assign bus.P_DATA         = p_data_q;
    assign bus.data_valid     = data_valid_q;
    assign bus.stop_err       = stop_err_q;
    assign bus.start_glitch   = start_glitch_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Self-checking bench for uart_rx_ctrl. Provides the external
//               edge/bit counter and mid-bit sampler, drives directed serial
//               frames and predicts each frame's outcome and timing from the
//               frame contents (events queue), compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

`ifdef UART_RX_PARITY_EN
    localparam bit c_PARITY_BUILT = 1'b1;
`else
    localparam bit c_PARITY_BUILT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_ctrl_if bus ();
    uart_rx_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External edge/bit counter and mid-bit sampler.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.edge_count  <= 5'd0;
            bus.bit_count   <= 4'd0;
            bus.sampled_bit <= 1'b1;
        end else begin
            if (!bus.counter_enable) begin
                bus.edge_count <= 5'd0;
                bus.bit_count  <= 4'd0;
            end else if (int'(bus.edge_count) == int'(bus.cfg_prescale) - 1) begin
                bus.edge_count <= 5'd0;
                bus.bit_count  <= bus.bit_count + 4'd1;
            end else begin
                bus.edge_count <= bus.edge_count + 5'd1;
            end
            if (bus.counter_enable && int'(bus.edge_count) == int'(bus.cfg_prescale) / 2)
                bus.sampled_bit <= bus.RX_IN;
        end
    end

    // ---------------- model: one event per frame ----------------
    typedef struct {
        int         s;      // cycle the receiver enters the frame
        int         d;      // cycle the outcome becomes visible
        bit         dv, pe, se, sg;
        logic [7:0] data;
        logic [5:0] cfg;
    } ev_t;

    ev_t        evq[$];
    ev_t        abort_ev;
    int         model_free = 0;
    logic [7:0] exp_pdata  = 8'h00;
    logic [5:0] exp_cfg    = 6'd8;
    int         last_fall  = 0;

    int n_cmp = 0;
    int n_bad = 0;
    int n_dv = 0, n_pe = 0, n_se = 0, n_sg = 0;
    int last_dv_cyc = 0;
    int dv_cycs[$];
    logic [7:0] dv_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        bit         e_dv, e_pe, e_se, e_sg, e_ce;
        logic [7:0] e_pd;
        logic [5:0] e_cfg;
        if (!rst) begin
            evq.delete();
            exp_pdata = 8'h00;
            exp_cfg   = 6'd8;
            e_dv = 0; e_pe = 0; e_se = 0; e_sg = 0; e_ce = 0;
            e_pd = 8'h00; e_cfg = 6'd8;
        end else begin
            e_dv = 0; e_pe = 0; e_se = 0; e_sg = 0; e_ce = 0;
            e_pd = exp_pdata; e_cfg = exp_cfg;
            if (evq.size() > 0) begin
                if (cyc >= evq[0].s) e_cfg = evq[0].cfg;
                if (cyc >= evq[0].s && cyc < evq[0].d) e_ce = 1'b1;
                if (cyc == evq[0].d) begin
                    e_dv = evq[0].dv; e_pe = evq[0].pe; e_se = evq[0].se; e_sg = evq[0].sg;
                    if (e_dv) e_pd = evq[0].data;
                    exp_pdata = e_pd;
                    exp_cfg   = e_cfg;
                    void'(evq.pop_front());
                end
            end
        end
        chk("data_valid",     32'(bus.data_valid),     32'(e_dv));
        chk("par_err",        32'(bus.par_err),        32'(e_pe));
        chk("stop_err",       32'(bus.stop_err),       32'(e_se));
        chk("start_glitch",   32'(bus.start_glitch),   32'(e_sg));
        chk("counter_enable", 32'(bus.counter_enable), 32'(e_ce));
        chk("P_DATA",         32'(bus.P_DATA),         32'(e_pd));
        chk("cfg_prescale",   32'(bus.cfg_prescale),   32'(e_cfg));
        if (rst) begin
            if (bus.data_valid === 1'b1) begin
                n_dv++; last_dv_cyc = cyc;
                dv_cycs.push_back(cyc); dv_data.push_back(bus.P_DATA);
            end
            if (bus.par_err === 1'b1)      n_pe++;
            if (bus.stop_err === 1'b1)     n_se++;
            if (bus.start_glitch === 1'b1) n_sg++;
        end
    end

    // Drive one frame starting at the current negedge and queue its predicted outcome.
    task automatic send_frame(input int p, input bit pen, input bit ptyp, input logic [7:0] data,
                              input bit line_par, input bit par_bit, input bit stop_bit,
                              input int p_mid);
        bit  bits[11];
        int  nl, k, n;
        bit  pact;
        ev_t ev;
        bus.Prescale = 6'(p);
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = ptyp;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        nl = 9;
        if (line_par) begin bits[9] = par_bit; nl = 10; end
        bits[nl] = stop_bit;
        nl = nl + 1;
        k    = cyc;
        pact = c_PARITY_BUILT && pen;
        n    = pact ? 11 : 10;
        ev.s    = (k + 1 > model_free) ? k + 1 : model_free;
        ev.d    = ev.s + n * p;
        ev.cfg  = 6'(p);
        ev.pe   = pact && (bits[9] != ((^data) ^ ptyp));
        ev.se   = !bits[n-1];
        ev.dv   = !ev.pe && !ev.se;
        ev.sg   = 1'b0;
        ev.data = data;
        evq.push_back(ev);
        model_free = ev.d + 1;
        last_fall  = k;
        for (int i = 0; i < nl; i++) begin
            bus.RX_IN = bits[i];
            if (i == 1) bus.Prescale = 6'(p_mid);
            repeat (p) @(negedge clk);
        end
        bus.RX_IN = 1'b1;
    endtask

    // Low pulse shorter than half a bit: must be rejected at the end of the start bit.
    task automatic send_glitch(input int p, input int len);
        ev_t ev;
        bus.Prescale = 6'(p);
        ev.s    = (cyc + 1 > model_free) ? cyc + 1 : model_free;
        ev.d    = ev.s + p;
        ev.cfg  = 6'(p);
        ev.dv   = 1'b0; ev.pe = 1'b0; ev.se = 1'b0; ev.sg = 1'b1;
        ev.data = 8'h00;
        evq.push_back(ev);
        model_free = ev.d + 1;
        bus.RX_IN = 1'b0;
        repeat (len) @(negedge clk);
        bus.RX_IN = 1'b1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int dv0, pe0, se0, sg0;

    initial begin
        bus.RX_IN    = 1'b1;
        bus.Prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        #2 rst = 1'b0;
        settle(3);
        chk("reset_P_DATA",         32'(bus.P_DATA),         32'h00);
        chk("reset_cfg_prescale",   32'(bus.cfg_prescale),   32'd8);
        chk("reset_counter_enable", 32'(bus.counter_enable), 32'd0);
        @(negedge clk); #2 rst = 1'b1;
        settle(3);

        // Unsupported ratio: a low line is ignored.
        @(negedge clk);
        bus.Prescale = 6'd10;
        bus.RX_IN    = 1'b0;
        settle(20);
        chk("bad_ratio_counter_enable", 32'(bus.counter_enable), 32'd0);
        @(negedge clk); bus.RX_IN = 1'b1;
        settle(3);

        // Prescale 8, no parity, 0xA5.
        @(negedge clk);
        dv0 = n_dv;
        send_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8);
        settle(4);
        chk("a5_valid_count", 32'(n_dv - dv0), 32'd1);
        chk("a5_P_DATA",      32'(bus.P_DATA), 32'hA5);
        chk("a5_latency",     32'(last_dv_cyc - last_fall), 32'd81);

        // Prescale 16, even parity, 0x03 with correct then wrong parity bit.
        @(negedge clk);
        dv0 = n_dv; se0 = n_se;
        send_frame(16, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 1'b1, 16);
        settle(4);
`ifdef UART_RX_PARITY_EN
        chk("par_ok_valid_count", 32'(n_dv - dv0), 32'd1);
        chk("par_ok_P_DATA",      32'(bus.P_DATA), 32'h03);
`else
        chk("nopar_stop_err_count", 32'(n_se - se0), 32'd1);
        chk("nopar_P_DATA_held",    32'(bus.P_DATA), 32'hA5);
`endif
        @(negedge clk);
        dv0 = n_dv; pe0 = n_pe;
        send_frame(16, 1'b1, 1'b0, 8'h03, 1'b1, 1'b1, 1'b1, 16);
        settle(4);
`ifdef UART_RX_PARITY_EN
        chk("par_bad_par_err_count", 32'(n_pe - pe0), 32'd1);
        chk("par_bad_valid_count",   32'(n_dv - dv0), 32'd0);
        chk("par_bad_P_DATA_held",   32'(bus.P_DATA), 32'h03);
`else
        chk("nopar_valid_count", 32'(n_dv - dv0), 32'd1);
        chk("nopar_P_DATA",      32'(bus.P_DATA), 32'h03);
`endif

        // Prescale 32, 4-cycle glitch.
        @(negedge clk);
        dv0 = n_dv; sg0 = n_sg;
        send_glitch(32, 4);
        settle(40);
        chk("glitch_count",          32'(n_sg - sg0), 32'd1);
        chk("glitch_valid_count",    32'(n_dv - dv0), 32'd0);
        chk("glitch_counter_enable", 32'(bus.counter_enable), 32'd0);

        // Stop bit 0 on 0x5A.
        @(negedge clk);
        dv0 = n_dv; se0 = n_se;
        send_frame(8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 8);
        settle(4);
        chk("stop0_stop_err_count", 32'(n_se - se0), 32'd1);
        chk("stop0_valid_count",    32'(n_dv - dv0), 32'd0);
        chk("stop0_P_DATA_held",    32'(bus.P_DATA), 32'h03);

        // Back-to-back 0x11 (ratio 8) then 0xEE (ratio 16), ratio changed mid-frame 1.
        @(negedge clk);
        dv0 = n_dv;
        send_frame(8,  1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 16);
        send_frame(16, 1'b0, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b1, 16);
        settle(4);
        chk("b2b_valid_count",  32'(n_dv - dv0), 32'd2);
        chk("b2b_first_byte",   32'(dv_data[dv_data.size()-2]), 32'h11);
        chk("b2b_second_byte",  32'(bus.P_DATA), 32'hEE);
        chk("b2b_valid_gap",    32'(dv_cycs[dv_cycs.size()-1] - dv_cycs[dv_cycs.size()-2]), 32'd161);
        chk("b2b_cfg_prescale", 32'(bus.cfg_prescale), 32'd16);

        // Reset during DATA (ratio 16 so the reset value 8 is observable).
        @(negedge clk);
        bus.Prescale = 6'd16;
        abort_ev.s = cyc + 1; abort_ev.d = cyc + 100000; abort_ev.cfg = 6'd16;
        abort_ev.dv = 1'b0; abort_ev.pe = 1'b0; abort_ev.se = 1'b0; abort_ev.sg = 1'b0;
        abort_ev.data = 8'h00;
        evq.push_back(abort_ev);
        bus.RX_IN = 1'b0;
        repeat (16) @(negedge clk);
        bus.RX_IN = 1'b1;
        repeat (40) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_counter_enable", 32'(bus.counter_enable), 32'd0);
        chk("midrst_data_valid",     32'(bus.data_valid),     32'd0);
        chk("midrst_P_DATA",         32'(bus.P_DATA),         32'h00);
        chk("midrst_cfg_prescale",   32'(bus.cfg_prescale),   32'd8);
        chk("midrst_errors",         32'({bus.par_err, bus.stop_err, bus.start_glitch}), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        model_free = 0;
        settle(4);

        // Frame after reset: 0x7E.
        @(negedge clk);
        dv0 = n_dv;
        send_frame(8, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b1, 8);
        settle(4);
        chk("post_rst_valid_count", 32'(n_dv - dv0), 32'd1);
        chk("post_rst_P_DATA",      32'(bus.P_DATA), 32'h7E);

        settle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port RX_IN, input, 1 bit: serial line, idle high.
REQ-004 The block SHALL have ports Prescale [5:0], PAR_EN [0:0] and PAR_TYP [0:0] as inputs: oversampling ratio, parity enable, and parity type (0 even, 1 odd).
REQ-005 The block SHALL have ports edge_count [4:0] and bit_count [3:0] as inputs, driven from the edge/bit counter.
REQ-006 The block SHALL have port sampled_bit, input, 1 bit: sampler output, valid at the last edge of each bit.
REQ-007 The block SHALL have ports counter_enable [0:0] and cfg_prescale [5:0] as outputs: counter run and latched ratio; the counter holds zero while counter_enable is low.
REQ-008 The block SHALL have ports P_DATA [7:0] and data_valid [0:0] as outputs: received byte and a one-cycle valid pulse.
REQ-009 The block SHALL have ports par_err, stop_err and start_glitch as outputs, 1 bit each: one-cycle error pulses.

Function
REQ-010 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and VALID.
REQ-011 bit_end SHALL be defined as edge_count == cfg_prescale-1.
REQ-012 In IDLE, RX_IN==0 with Prescale in {8,16,32} SHALL cause a transition to START next cycle. On that transition: cfg_prescale<=Prescale, PAR_EN/PAR_TYP latched, shift register cleared.
REQ-013 In IDLE, Prescale not in {8,16,32} SHALL cause RX_IN to be ignored; the FSM stays in IDLE.
REQ-014 counter_enable SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE and VALID.
REQ-015 START on bit_end: sampled_bit==1 SHALL pulse start_glitch and go to IDLE; sampled_bit==0 SHALL go to DATA.
REQ-016 DATA on bit_end SHALL shift sampled_bit in LSB-first (new bit into bit 7, shift right).
REQ-017 After the 8th data bit (bit_count==8 at bit_end), the FSM SHALL go to PARITY if latched PAR_EN, otherwise to STOP.
REQ-018 PARITY on bit_end: expected = XOR of the 8 data bits, XOR latched PAR_TYP. A mismatch SHALL record a pending parity error. The FSM SHALL then go to STOP.
REQ-019 STOP on bit_end with sampled_bit==1 and no pending error SHALL go to VALID and load P_DATA from the shift register.
REQ-020 STOP on bit_end otherwise SHALL pulse stop_err (if sampled_bit==0) and/or par_err (if pending), and go to IDLE; P_DATA is unchanged.
REQ-021 VALID SHALL last exactly one cycle with data_valid=1. The next state SHALL be START if RX_IN==0 (back-to-back frame, with config re-latched), else IDLE.
REQ-022 Changes to Prescale, PAR_EN or PAR_TYP mid-frame SHALL NOT affect the current frame.
REQ-023 Error pulses and data_valid SHALL each be exactly one cycle long and never asserted simultaneously with data_valid.
REQ-024 P_DATA SHALL hold its last valid byte until the next VALID.

Reset
REQ-025 On rst low, asynchronously: state=IDLE, counter_enable=0, cfg_prescale=8, P_DATA=0, data_valid=0, all error outputs 0, shift register and pending error cleared.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no pulses; after release, the block waits in IDLE for a new falling level.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined SHALL enable the PARITY state and par_err, as specified above.
REQ-028 Macro UART_RX_PARITY_EN undefined SHALL make PAR_EN and PAR_TYP ignored: DATA always goes to STOP, and par_err is tied to 0.

Verification
REQ-029 The bench SHALL cover: Prescale=8, no parity, frame 0/0xA5 LSB-first/1 -> data_valid one cycle, P_DATA=0xA5, 10x8 bit times after start.
REQ-030 The bench SHALL cover: Prescale=16, PAR_EN=1, PAR_TYP=0, byte 0x03 with parity bit 0 -> P_DATA=0x03; the same byte with parity bit 1 -> par_err pulse, P_DATA unchanged.
REQ-031 The bench SHALL cover: Prescale=32, a 4-edge low glitch then RX_IN high -> start_glitch pulse, FSM in IDLE, no data_valid.
REQ-032 The bench SHALL cover: stop bit 0 on byte 0x5A -> stop_err pulse, data_valid stays 0.
REQ-033 The bench SHALL cover: two back-to-back frames 0x11 then 0xEE with Prescale changed 8->16 during frame 1 -> frame 1 uses 8, frame 2 uses 16, and both bytes are valid.
REQ-034 The bench SHALL cover: rst asserted during DATA -> all outputs 0 immediately, no pulse; the next frame 0x7E is received correctly.
